// File: rtl/regfile_wordline_nw.sv
// Register file: one-hot write wordline, two read ports with write-to-read bypass.
// Read latency 0 (READ_REG=0) or 1 (READ_REG=1); no backpressure, a write is accepted every cycle.
module regfile_wordline_nw #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int ZERO_R0  = 1,
  parameter int READ_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WriteReg,
  input  logic [ADDR_W-1:0]      DstReg,
  input  logic [DATA_W-1:0]      DstData,
  input  logic [ADDR_W-1:0]      SrcReg1,
  input  logic [ADDR_W-1:0]      SrcReg2,
  output logic [DATA_W-1:0]      SrcData1,
  output logic [DATA_W-1:0]      SrcData2,
  output logic [(2**ADDR_W)-1:0] Wordline
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [N];
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              byp1;
  logic              byp2;
  logic              src1_zero;
  logic              src2_zero;

  for (genvar i = 0; i < N; i++) begin : g_wl
    assign Wordline[i] = WriteReg && (DstReg == ADDR_W'(i));
  end

  // R0 is tied off when hardwired to zero; the wordline still fires but nothing stores it.
  for (genvar i = 0; i < N; i++) begin : g_reg
    if ((ZERO_R0 != 0) && (i == 0)) begin : g_zero
      assign rf[i] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (Wordline[i]) begin
          q <= DstData;
        end
      end
      assign rf[i] = q;
    end
  end

  assign src1_zero = (ZERO_R0 != 0) && (SrcReg1 == '0);
  assign src2_zero = (ZERO_R0 != 0) && (SrcReg2 == '0);
  assign byp1      = WriteReg && (DstReg == SrcReg1) && !src1_zero;
  assign byp2      = WriteReg && (DstReg == SrcReg2) && !src2_zero;

  always_comb begin
    rd1 = byp1 ? DstData : rf[SrcReg1];
    rd2 = byp2 ? DstData : rf[SrcReg2];
  end

  if (READ_REG != 0) begin : g_rd_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        SrcData1 <= '0;
        SrcData2 <= '0;
      end else begin
        SrcData1 <= rd1;
        SrcData2 <= rd2;
      end
    end
  end else begin : g_rd_comb
    assign SrcData1 = rd1;
    assign SrcData2 = rd2;
  end

endmodule

// File: tb/tb_regfile_wordline_nw.sv
// Directed and random checks of regfile_wordline_nw in three configurations sharing one stimulus.
module tb_regfile_wordline_nw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  dst = '0;
  logic [4:0]  s1 = '0;
  logic [4:0]  s2 = '0;
  logic [15:0] dat = '0;

  logic [15:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;
  logic [15:0] a_wl;
  logic [31:0] b_wl;
  logic [7:0]  c_wl;

  logic [15:0] model_a [16];
  logic [15:0] model_b [32];
  logic [15:0] model_c [8];
  logic [15:0] pend_b1, pend_b2, pend_c1, pend_c2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // A: 16 regs, zero R0, combinational read
  regfile_wordline_nw #(.ADDR_W(4), .DATA_W(16), .ZERO_R0(1), .READ_REG(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .WriteReg(we), .DstReg(dst[3:0]), .DstData(dat),
    .SrcReg1(s1[3:0]), .SrcReg2(s2[3:0]), .SrcData1(a_d1), .SrcData2(a_d2), .Wordline(a_wl));

  // B: 32 regs, ordinary R0, registered read
  regfile_wordline_nw #(.ADDR_W(5), .DATA_W(16), .ZERO_R0(0), .READ_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .WriteReg(we), .DstReg(dst), .DstData(dat),
    .SrcReg1(s1), .SrcReg2(s2), .SrcData1(b_d1), .SrcData2(b_d2), .Wordline(b_wl));

  // C: 8 regs, zero R0, registered read
  regfile_wordline_nw #(.ADDR_W(3), .DATA_W(16), .ZERO_R0(1), .READ_REG(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .WriteReg(we), .DstReg(dst[2:0]), .DstData(dat),
    .SrcReg1(s1[2:0]), .SrcReg2(s2[2:0]), .SrcData1(c_d1), .SrcData2(c_d2), .Wordline(c_wl));

  function automatic logic [15:0] exp_a(input logic [3:0] s);
    if (s == 4'd0) return 16'h0000;
    if (we && dst[3:0] == s) return dat;
    return model_a[s];
  endfunction

  function automatic logic [15:0] exp_b(input logic [4:0] s);
    if (we && dst == s) return dat;
    return model_b[s];
  endfunction

  function automatic logic [15:0] exp_c(input logic [2:0] s);
    if (s == 3'd0) return 16'h0000;
    if (we && dst[2:0] == s) return dat;
    return model_c[s];
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 32; i++) model_b[i] = '0;
    for (int i = 0; i < 16; i++) model_a[i] = '0;
    for (int i = 0; i < 8; i++)  model_c[i] = '0;
    pend_b1 = '0; pend_b2 = '0; pend_c1 = '0; pend_c2 = '0;
  endtask

  task automatic apply(input logic w, input logic [4:0] d, input logic [15:0] v,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; dst = d; dat = v; s1 = r1; s2 = r2;
    #2;
  endtask

  // Advance one rising edge; registered-read expectations are captured from pre-edge state.
  task automatic tick();
    logic at_edge;
    at_edge = rst_n;
    pend_b1 = at_edge ? exp_b(s1)      : 16'h0;
    pend_b2 = at_edge ? exp_b(s2)      : 16'h0;
    pend_c1 = at_edge ? exp_c(s1[2:0]) : 16'h0;
    pend_c2 = at_edge ? exp_c(s2[2:0]) : 16'h0;
    @(posedge clk);
    #1;
    if (at_edge && we) begin
      model_a[dst[3:0]] = dat;
      model_b[dst]      = dat;
      model_c[dst[2:0]] = dat;
    end
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    clear_models();
    #1;
  endtask

  task automatic test_reset();
    apply(1'b0, 5'd3, 16'h0000, 5'd3, 5'd15);
    nvec++; if (a_d1 !== 16'h0 || a_d2 !== 16'h0) begin nerr++;
      $display("FAIL reset_init_a: got %h/%h want 0000/0000", a_d1, a_d2); end
    nvec++; if (b_d1 !== 16'h0 || c_d1 !== 16'h0) begin nerr++;
      $display("FAIL reset_init_reg: got b=%h c=%h want 0000", b_d1, c_d1); end
    rst_n = 1'b1;
    apply(1'b1, 5'd3, 16'h1111, 5'd0, 5'd0); tick();
    apply(1'b1, 5'd7, 16'h2222, 5'd0, 5'd0); tick();
    apply(1'b0, 5'd0, 16'h0000, 5'd3, 5'd7); tick();
    nvec++; if (a_d1 !== 16'h1111 || a_d2 !== 16'h2222) begin nerr++;
      $display("FAIL reset_prewrite_a: got %h/%h want 1111/2222", a_d1, a_d2); end
    nvec++; if (b_d1 !== 16'h1111 || b_d2 !== 16'h2222) begin nerr++;
      $display("FAIL reset_prewrite_b: got %h/%h want 1111/2222", b_d1, b_d2); end
    reset_assert();
    nvec++; if (a_d1 !== 16'h0 || a_d2 !== 16'h0) begin nerr++;
      $display("FAIL reset_async_a: got %h/%h want 0000/0000", a_d1, a_d2); end
    nvec++; if (b_d1 !== 16'h0 || b_d2 !== 16'h0) begin nerr++;
      $display("FAIL reset_async_b: got %h/%h want 0000/0000", b_d1, b_d2); end
    apply(1'b1, 5'd3, 16'hABCD, 5'd7, 5'd7); tick();
    nvec++; if (b_d1 !== 16'h0) begin nerr++;
      $display("FAIL reset_hold_b: got %h want 0000", b_d1); end
    rst_n = 1'b1;
    apply(1'b0, 5'd0, 16'h0000, 5'd3, 5'd7);
    nvec++; if (a_d1 !== 16'h0 || a_d2 !== 16'h0) begin nerr++;
      $display("FAIL reset_blocks_write: got %h/%h want 0000/0000", a_d1, a_d2); end
    tick();
  endtask

  task automatic test_decoder();
    logic [15:0] one;
    one = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 5'(i), 16'h0100 + 16'(i), 5'd0, 5'd0);
      nvec++; if (a_wl !== (one << i)) begin nerr++;
        $display("FAIL decoder_wl_%0d: got %h want %h", i, a_wl, one << i); end
      tick();
    end
    apply(1'b0, 5'd9, 16'h0000, 5'd0, 5'd0);
    nvec++; if (a_wl !== 16'h0 || b_wl !== 32'h0 || c_wl !== 8'h0) begin nerr++;
      $display("FAIL decoder_idle: got %h/%h/%h want 0", a_wl, b_wl, c_wl); end
    apply(1'b1, 5'd20, 16'h0000, 5'd0, 5'd0);
    nvec++; if (b_wl !== 32'h0010_0000) begin nerr++;
      $display("FAIL decoder_wl_b20: got %h want 00100000", b_wl); end
    apply(1'b0, 5'd0, 16'h0000, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_write_read();
    apply(1'b1, 5'd3, 16'hA5A5, 5'd0, 5'd0);  tick();
    apply(1'b1, 5'd15, 16'h1234, 5'd0, 5'd0); tick();
    apply(1'b0, 5'd0, 16'h0000, 5'd3, 5'd15);
    nvec++; if (a_d1 !== 16'hA5A5 || a_d2 !== 16'h1234) begin nerr++;
      $display("FAIL write_read_a: got %h/%h want a5a5/1234", a_d1, a_d2); end
    tick();
    nvec++; if (b_d1 !== 16'hA5A5 || b_d2 !== 16'h1234) begin nerr++;
      $display("FAIL write_read_b: got %h/%h want a5a5/1234", b_d1, b_d2); end
  endtask

  task automatic test_bypass();
    apply(1'b1, 5'd5, 16'h0001, 5'd0, 5'd0); tick();
    apply(1'b1, 5'd5, 16'hBEEF, 5'd5, 5'd5);
    nvec++; if (a_d1 !== 16'hBEEF || a_d2 !== 16'hBEEF) begin nerr++;
      $display("FAIL bypass_a: got %h/%h want beef/beef", a_d1, a_d2); end
    tick();
    nvec++; if (b_d1 !== 16'hBEEF || b_d2 !== 16'hBEEF || c_d1 !== 16'hBEEF) begin nerr++;
      $display("FAIL bypass_reg: got %h/%h/%h want beef", b_d1, b_d2, c_d1); end
    apply(1'b0, 5'd0, 16'h0000, 5'd5, 5'd3);
    nvec++; if (a_d1 !== 16'hBEEF || a_d2 !== 16'hA5A5) begin nerr++;
      $display("FAIL bypass_stored: got %h/%h want beef/a5a5", a_d1, a_d2); end
    tick();
  endtask

  task automatic test_zero_reg();
    apply(1'b1, 5'd0, 16'hFFFF, 5'd0, 5'd0);
    nvec++; if (a_d1 !== 16'h0 || a_d2 !== 16'h0) begin nerr++;
      $display("FAIL zero_same_a: got %h/%h want 0000/0000", a_d1, a_d2); end
    tick();
    nvec++; if (b_d1 !== 16'hFFFF || c_d1 !== 16'h0) begin nerr++;
      $display("FAIL zero_same_reg: got b=%h c=%h want ffff/0000", b_d1, c_d1); end
    apply(1'b0, 5'd0, 16'h0000, 5'd0, 5'd0);
    nvec++; if (a_d1 !== 16'h0) begin nerr++;
      $display("FAIL zero_next_a: got %h want 0000", a_d1); end
    tick();
    nvec++; if (b_d2 !== 16'hFFFF || c_d2 !== 16'h0) begin nerr++;
      $display("FAIL zero_next_reg: got b=%h c=%h want ffff/0000", b_d2, c_d2); end
  endtask

  task automatic test_random();
    logic pulse;
    logic [15:0] ea1, ea2;
    for (int n = 0; n < 400; n++) begin
      pulse = ($urandom_range(0, 29) == 0);
      apply(1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom),
            5'($urandom), ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom));
      if (pulse) reset_assert();
      ea1 = exp_a(s1[3:0]);
      ea2 = exp_a(s2[3:0]);
      nvec++; if (a_d1 !== ea1 || a_d2 !== ea2) begin nerr++;
        $display("FAIL rand_a[%0d]: got %h/%h want %h/%h", n, a_d1, a_d2, ea1, ea2); end
      nvec++; if (c_wl !== (we ? (8'h01 << dst[2:0]) : 8'h00)) begin nerr++;
        $display("FAIL rand_wl[%0d]: got %h", n, c_wl); end
      tick();
      nvec++; if (b_d1 !== pend_b1 || b_d2 !== pend_b2) begin nerr++;
        $display("FAIL rand_b[%0d]: got %h/%h want %h/%h", n, b_d1, b_d2, pend_b1, pend_b2); end
      nvec++; if (c_d1 !== pend_c1 || c_d2 !== pend_c2) begin nerr++;
        $display("FAIL rand_c[%0d]: got %h/%h want %h/%h", n, c_d1, c_d2, pend_c1, pend_c2); end
      if (pulse) rst_n = 1'b1;
    end
  endtask

  initial begin
    clear_models();
    #6;
    test_reset();
    test_decoder();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
